// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes and datapath selects.
// The optional jal path is enabled with MULTICYCLE_CONTROL_JAL_EN.
package multicycle_control_pkg;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EX   = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;
    localparam logic [3:0] S_JAL       = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG       = 2'b00;
    localparam logic [1:0] SRCB_FOUR      = 2'b01;
    localparam logic [1:0] SRCB_IMM       = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHIFT = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC  = 2'b10;

endpackage

// File: rtl/mcc_output_decode.sv
// Combinational map from control state (plus mem_ready in FETCH) to datapath controls.
// The JAL state row exists only under MULTICYCLE_CONTROL_JAL_EN.
module mcc_output_decode
    import multicycle_control_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    input  logic               mem_ready,
    input  logic               is_bne,
    input  logic               enable,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               alu_src_a,
    output logic               reg_write,
    output logic               branch_ne,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         pc_source,
    output logic [1:0]         alu_op,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         reg_dst
);

    // enable low (reset) leaves every control at its inactive default
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        branch_ne     = 1'b0;
        mem_to_reg    = MEMTOREG_ALU;
        pc_source     = PC_ALU;
        alu_op        = ALU_ADD;
        alu_src_b     = SRCB_REG;
        reg_dst       = REGDST_RT;
        if (enable) begin
            case (state)
                STATE_W'(S_FETCH): begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                STATE_W'(S_DECODE):   alu_src_b = SRCB_IMM_SHIFT;
                STATE_W'(S_MEM_ADDR): begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                STATE_W'(S_MEM_READ): begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                STATE_W'(S_MEM_WB): begin
                    reg_write  = 1'b1;
                    mem_to_reg = MEMTOREG_MEM;
                end
                STATE_W'(S_MEM_WRITE): begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                STATE_W'(S_EXECUTE): begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                STATE_W'(S_R_WB): begin
                    reg_write = 1'b1;
                    reg_dst   = REGDST_RD;
                end
                STATE_W'(S_BRANCH): begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PC_ALUOUT;
                    branch_ne     = is_bne;
                end
                STATE_W'(S_JUMP): begin
                    pc_write  = 1'b1;
                    pc_source = PC_JUMP;
                end
                STATE_W'(S_ADDI_EX): begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                STATE_W'(S_ADDI_WB):  reg_write = 1'b1;
`ifdef MULTICYCLE_CONTROL_JAL_EN
                STATE_W'(S_JAL): begin
                    pc_write   = 1'b1;
                    pc_source  = PC_JUMP;
                    reg_write  = 1'b1;
                    reg_dst    = REGDST_RA;
                    mem_to_reg = MEMTOREG_PC;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready wait timeout and illegal-opcode pulse.
// Define MULTICYCLE_CONTROL_JAL_EN to add the jal decode and JAL state.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W  = 6,
    parameter int STATE_W   = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                alu_src_a,
    output logic                reg_write,
    output logic                branch_ne,
    output logic [1:0]          mem_to_reg,
    output logic [1:0]          pc_source,
    output logic [1:0]          alu_op,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          reg_dst,
    output logic                illegal_op,
    output logic                mem_timeout,
    output logic [STATE_W-1:0]  state
);

    logic [STATE_W-1:0]   next_state;
    logic [TIMEOUT_W-1:0] wait_count;
    logic [5:0]           op6;
    logic                 in_wait;
    logic                 timeout_hit;
    logic                 illegal_next;

    assign op6 = 6'(opcode);
    assign in_wait = (state == STATE_W'(S_FETCH)) || (state == STATE_W'(S_MEM_READ)) ||
                     (state == STATE_W'(S_MEM_WRITE));
    // a ready in the saturating cycle counts as completion, not timeout
    assign timeout_hit = in_wait && !mem_ready && (&wait_count);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= STATE_W'(S_FETCH);
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = STATE_W'(S_FETCH);
        illegal_next = 1'b0;
        case (state)
            STATE_W'(S_FETCH):
                next_state = mem_ready ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
            STATE_W'(S_DECODE): begin
                case (op6)
                    OP_LW, OP_SW:    next_state = STATE_W'(S_MEM_ADDR);
                    OP_RTYPE:        next_state = STATE_W'(S_EXECUTE);
                    OP_BEQ, OP_BNE:  next_state = STATE_W'(S_BRANCH);
                    OP_J:            next_state = STATE_W'(S_JUMP);
                    OP_ADDI:         next_state = STATE_W'(S_ADDI_EX);
`ifdef MULTICYCLE_CONTROL_JAL_EN
                    OP_JAL:          next_state = STATE_W'(S_JAL);
`endif
                    default:         illegal_next = 1'b1;
                endcase
            end
            STATE_W'(S_MEM_ADDR):
                next_state = (op6 == OP_SW) ? STATE_W'(S_MEM_WRITE) : STATE_W'(S_MEM_READ);
            STATE_W'(S_MEM_READ):
                next_state = mem_ready ? STATE_W'(S_MEM_WB) : STATE_W'(S_MEM_READ);
            STATE_W'(S_MEM_WRITE):
                next_state = mem_ready ? STATE_W'(S_FETCH) : STATE_W'(S_MEM_WRITE);
            STATE_W'(S_EXECUTE):  next_state = STATE_W'(S_R_WB);
            STATE_W'(S_ADDI_EX):  next_state = STATE_W'(S_ADDI_WB);
            STATE_W'(S_MEM_WB), STATE_W'(S_R_WB), STATE_W'(S_BRANCH),
            STATE_W'(S_JUMP), STATE_W'(S_ADDI_WB):
                next_state = STATE_W'(S_FETCH);
`ifdef MULTICYCLE_CONTROL_JAL_EN
            STATE_W'(S_JAL):      next_state = STATE_W'(S_FETCH);
`endif
            default:              illegal_next = 1'b1;
        endcase
        if (timeout_hit) begin
            next_state = STATE_W'(S_FETCH);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_count <= '0;
        end else if (!in_wait || mem_ready || timeout_hit || (next_state != state)) begin
            wait_count <= '0;
        end else begin
            wait_count <= wait_count + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            illegal_op  <= illegal_next;
            mem_timeout <= timeout_hit;
        end
    end

    mcc_output_decode #(
        .STATE_W(STATE_W)
    ) u_output_decode (
        .state         (state),
        .mem_ready     (mem_ready),
        .is_bne        (op6 == OP_BNE),
        .enable        (!reset),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .alu_src_a     (alu_src_a),
        .reg_write     (reg_write),
        .branch_ne     (branch_ne),
        .mem_to_reg    (mem_to_reg),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_b     (alu_src_b),
        .reg_dst       (reg_dst)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expectations are queued when inputs are driven
// and popped when the cycle's outputs are sampled. Honours MULTICYCLE_CONTROL_JAL_EN.
module tb_multicycle_control;

    localparam int TW = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       alu_src_a, reg_write, branch_ne, illegal_op, mem_timeout;
    logic [1:0] mem_to_reg, pc_source, alu_op, alu_src_b, reg_dst;
    logic [3:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    int         q_state[$];
    logic [18:0] q_ctrl[$];
    logic       q_ill[$];
    logic       q_to[$];
    string      q_tag[$];

    wire [18:0] ctrl_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                            alu_src_a, reg_write, branch_ne, mem_to_reg, pc_source, alu_op,
                            alu_src_b, reg_dst};

    multicycle_control #(
        .OPCODE_W(6), .STATE_W(4), .TIMEOUT_W(TW)
    ) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .alu_src_a(alu_src_a), .reg_write(reg_write), .branch_ne(branch_ne),
        .mem_to_reg(mem_to_reg), .pc_source(pc_source), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .reg_dst(reg_dst), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clock = ~clock;

    // reference control table, keyed by state number
    function automatic logic [18:0] expCtrl(input int st, input logic rdy, input logic bne,
                                            input logic rst);
        logic pw, pwc, iod, mr, mw, irw, asa, rw, bn;
        logic [1:0] m2r, pcs, aop, asb, rd;
        {pw, pwc, iod, mr, mw, irw, asa, rw, bn} = '0;
        {m2r, pcs, aop, asb, rd} = '0;
        if (!rst) begin
            case (st)
                0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
                1:  asb = 2'b11;
                2:  begin asa = 1; asb = 2'b10; end
                3:  begin mr = 1; iod = 1; end
                4:  begin rw = 1; m2r = 2'b01; end
                5:  begin mw = 1; iod = 1; end
                6:  begin asa = 1; aop = 2'b10; end
                7:  begin rw = 1; rd = 2'b01; end
                8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; bn = bne; end
                9:  begin pw = 1; pcs = 2'b10; end
                10: begin asa = 1; asb = 2'b10; end
                11: rw = 1;
                12: begin pw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
                default: ;
            endcase
        end
        return {pw, pwc, iod, mr, mw, irw, asa, rw, bn, m2r, pcs, aop, asb, rd};
    endfunction

    task automatic checkOutput();
        int es; logic [18:0] ec; logic ei, et; string tg;
        tests_run++;
        assert (q_state.size() > 0) else begin
            tests_failed++;
            $error("[TB] FAIL scoreboard_empty: got 0 entries expected >0");
        end
        if (q_state.size() > 0) begin
            es = q_state.pop_front(); ec = q_ctrl.pop_front();
            ei = q_ill.pop_front();   et = q_to.pop_front(); tg = q_tag.pop_front();
            tests_run++;
            assert (state === 4'(es)) else begin
                tests_failed++;
                $error("[TB] FAIL %s state: got %0d expected %0d", tg, state, es);
            end
            tests_run++;
            assert (ctrl_obs === ec) else begin
                tests_failed++;
                $error("[TB] FAIL %s ctrl: got %b expected %b", tg, ctrl_obs, ec);
            end
            tests_run++;
            assert (illegal_op === ei) else begin
                tests_failed++;
                $error("[TB] FAIL %s illegal_op: got %b expected %b", tg, illegal_op, ei);
            end
            tests_run++;
            assert (mem_timeout === et) else begin
                tests_failed++;
                $error("[TB] FAIL %s mem_timeout: got %b expected %b", tg, mem_timeout, et);
            end
        end
    endtask

    // called just after a falling edge; checks the cycle before the next rising edge
    task automatic applyStimulus(input logic [5:0] op, input logic rdy, input int st,
                                 input logic ill, input logic to, input string tag);
        opcode = op;
        mem_ready = rdy;
        q_state.push_back(st);
        q_ctrl.push_back(expCtrl(st, rdy, op == 6'h05, reset));
        q_ill.push_back(ill);
        q_to.push_back(to);
        q_tag.push_back(tag);
        #3;
        checkOutput();
        @(negedge clock);
    endtask

    initial begin
        @(negedge clock);
        for (int i = 0; i < 3; i++) applyStimulus(6'h23, 1, 0, 0, 0, "reset_hold");
        reset = 1'b0;

        applyStimulus(6'h23, 1, 0, 0, 0, "lw_fetch");
        applyStimulus(6'h23, 1, 1, 0, 0, "lw_decode");
        applyStimulus(6'h23, 1, 2, 0, 0, "lw_addr");
        applyStimulus(6'h23, 1, 3, 0, 0, "lw_read");
        applyStimulus(6'h23, 1, 4, 0, 0, "lw_wb");

        applyStimulus(6'h04, 1, 0, 0, 0, "beq_fetch");
        applyStimulus(6'h04, 1, 1, 0, 0, "beq_decode");
        applyStimulus(6'h04, 1, 8, 0, 0, "beq_branch");
        applyStimulus(6'h05, 1, 0, 0, 0, "bne_fetch");
        applyStimulus(6'h05, 1, 1, 0, 0, "bne_decode");
        applyStimulus(6'h05, 1, 8, 0, 0, "bne_branch");

        applyStimulus(6'h2B, 1, 0, 0, 0, "sw_fetch");
        applyStimulus(6'h2B, 1, 1, 0, 0, "sw_decode");
        applyStimulus(6'h2B, 1, 2, 0, 0, "sw_addr");
        for (int i = 0; i < 5; i++) applyStimulus(6'h2B, 0, 5, 0, 0, "sw_stall");
        applyStimulus(6'h2B, 1, 5, 0, 0, "sw_done");

        for (int i = 0; i < 8; i++) applyStimulus(6'h00, 0, 0, 0, 0, "fetch_stall");
        applyStimulus(6'h00, 0, 0, 0, 1, "fetch_timeout");
        applyStimulus(6'h00, 0, 0, 0, 0, "fetch_restart");

        applyStimulus(6'h3F, 1, 0, 0, 0, "ill_fetch");
        applyStimulus(6'h3F, 1, 1, 0, 0, "ill_decode");
        applyStimulus(6'h03, 1, 0, 1, 0, "ill_pulse");
        applyStimulus(6'h03, 1, 1, 0, 0, "jal_decode");
`ifdef MULTICYCLE_CONTROL_JAL_EN
        applyStimulus(6'h03, 1, 12, 0, 0, "jal_state");
        applyStimulus(6'h08, 1, 0, 0, 0, "addi_fetch");
`else
        applyStimulus(6'h08, 1, 0, 1, 0, "jal_illegal");
`endif
        applyStimulus(6'h08, 1, 1, 0, 0, "addi_decode");
        applyStimulus(6'h08, 1, 10, 0, 0, "addi_ex");
        applyStimulus(6'h08, 1, 11, 0, 0, "addi_wb");

        applyStimulus(6'h23, 1, 0, 0, 0, "sat_fetch");
        applyStimulus(6'h23, 1, 1, 0, 0, "sat_decode");
        applyStimulus(6'h23, 1, 2, 0, 0, "sat_addr");
        for (int i = 0; i < 7; i++) applyStimulus(6'h23, 0, 3, 0, 0, "sat_stall");
        applyStimulus(6'h23, 1, 3, 0, 0, "sat_ready_wins");
        applyStimulus(6'h23, 1, 4, 0, 0, "sat_wb");

        applyStimulus(6'h02, 1, 0, 0, 0, "j_fetch");
        applyStimulus(6'h02, 1, 1, 0, 0, "j_decode");
        applyStimulus(6'h02, 1, 9, 0, 0, "j_jump");

        applyStimulus(6'h00, 1, 0, 0, 0, "r_fetch");
        applyStimulus(6'h00, 1, 1, 0, 0, "r_decode");
        opcode = 6'h00;
        mem_ready = 1'b1;
        q_state.push_back(6);
        q_ctrl.push_back(expCtrl(6, 1'b1, 1'b0, 1'b0));
        q_ill.push_back(1'b0);
        q_to.push_back(1'b0);
        q_tag.push_back("r_execute");
        #2;
        checkOutput();
        #1 reset = 1'b1;
        #1;
        tests_run++;
        assert (state === 4'd0) else begin
            tests_failed++;
            $error("[TB] FAIL async_reset_state: got %0d expected 0", state);
        end
        tests_run++;
        assert (ctrl_obs === 19'd0) else begin
            tests_failed++;
            $error("[TB] FAIL async_reset_ctrl: got %b expected 0", ctrl_obs);
        end
        @(negedge clock);
        applyStimulus(6'h00, 1, 0, 0, 0, "reset_again");
        reset = 1'b0;
        applyStimulus(6'h00, 1, 0, 0, 0, "post_reset_fetch");
        applyStimulus(6'h00, 1, 1, 0, 0, "post_reset_decode");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
